// File: rtl/twiddle_loader_if.sv
// Stream-in / dual-port-RAM-out bundle for the twiddle loader.
// The slave modport is the loader; the master modport is the source and RAM side.
interface twiddle_loader_if #(
  parameter int WORD_SZ = 8,
  parameter int ADDR_SZ = 4
);
  logic [WORD_SZ-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_SZ-1:0] address_a;
  logic [ADDR_SZ-1:0] address_b;
  logic [WORD_SZ-1:0] data_a;
  logic [WORD_SZ-1:0] data_b;
  logic               wren_a;
  logic               wren_b;
  logic               rden_a;
  logic               rden_b;

  modport master (
    output in_data, in_valid,
    input  in_ready, address_a, address_b, data_a, data_b,
           wren_a, wren_b, rden_a, rden_b
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, address_a, address_b, data_a, data_b,
           wren_a, wren_b, rden_a, rden_b
  );
endinterface

// File: rtl/twiddle_loader.sv
// Collects twiddle words in pairs from a valid/ready stream and writes each pair
// to a dual-port RAM, optionally conjugating (saturating) the imaginary half.
//
// state  | meaning
// IDLE   | waiting for i_start
// FILL_A | waiting for the even word of pair k
// FILL_B | waiting for the odd word of pair k
// WRITE  | one-cycle dual write of pair k
// DONE   | one-cycle o_done pulse
module twiddle_loader #(
  parameter int WORD_SZ = 8,
  parameter int ADDR_SZ = 4,
  parameter int DEPTH   = 16
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_start,
  input  logic             i_conj,
  twiddle_loader_if.slave  bus,
  output logic             o_busy,
  output logic             o_done
);
  localparam int HALF = WORD_SZ / 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL_A = 3'd1;
  localparam logic [2:0] S_FILL_B = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [ADDR_SZ-1:0] LAST_K = ADDR_SZ'(DEPTH / 2 - 1);

  logic [2:0]         state;
  logic [ADDR_SZ-1:0] k;
  logic               conj_q;
  logic [WORD_SZ-1:0] hold_a;
  logic [WORD_SZ-1:0] cap_word;

  // Negating the most negative imaginary value would overflow, so clamp it to max.
  function automatic logic [WORD_SZ-1:0] conj_word(input logic [WORD_SZ-1:0] w);
    logic [HALF-1:0] im;
    im = w[HALF-1:0];
    if (im == {1'b1, {(HALF-1){1'b0}}})
      im = {1'b0, {(HALF-1){1'b1}}};
    else
      im = ~im + 1'b1;
    return {w[WORD_SZ-1:HALF], im};
  endfunction

  always_comb begin
    cap_word = bus.in_data;
    if (conj_q)
      cap_word = conj_word(bus.in_data);
  end

  assign bus.in_ready = (state == S_FILL_A) || (state == S_FILL_B);
  assign bus.wren_a   = (state == S_WRITE);
  assign bus.wren_b   = (state == S_WRITE);
  assign bus.rden_a   = 1'b0;
  assign bus.rden_b   = 1'b0;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state         <= S_IDLE;
      k             <= '0;
      conj_q        <= 1'b0;
      hold_a        <= '0;
      bus.address_a <= '0;
      bus.address_b <= '0;
      bus.data_a    <= '0;
      bus.data_b    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state  <= S_FILL_A;
            conj_q <= i_conj;
            k      <= '0;
          end
        end
        S_FILL_A: begin
          if (bus.in_valid) begin
            hold_a <= cap_word;
            state  <= S_FILL_B;
          end
        end
        S_FILL_B: begin
          // data_b doubles as holding register B; the pair is staged for WRITE here
          if (bus.in_valid) begin
            bus.data_b    <= cap_word;
            bus.data_a    <= hold_a;
            bus.address_a <= {k[ADDR_SZ-2:0], 1'b0};
            bus.address_b <= {k[ADDR_SZ-2:0], 1'b1};
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (k == LAST_K) begin
            state <= S_DONE;
          end else begin
            k     <= k + 1'b1;
            state <= S_FILL_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_twiddle_loader.sv
// Bench for twiddle_loader at WORD_SZ=8, DEPTH=4: directed vectors plus random loads
// checked against a write-log model built from the pairing and conjugation rules.
module tb_twiddle_loader;
  logic i_CLK;
  logic i_RESET;
  logic i_start;
  logic i_conj;
  logic o_busy;
  logic o_done;

  twiddle_loader_if #(.WORD_SZ(8), .ADDR_SZ(4)) bus ();

  twiddle_loader #(.WORD_SZ(8), .ADDR_SZ(4), .DEPTH(4)) dut (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_start (i_start),
    .i_conj  (i_conj),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] addr_a;
    logic [7:0] data_a;
    logic [3:0] addr_b;
    logic [7:0] data_b;
    logic       we_a;
    logic       we_b;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  wr_t  wr_q[$];
  int   done_q[$];
  bit   rden_seen = 0;
  logic [7:0] words[4];

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;
  always @(posedge i_CLK) cyc <= cyc + 1;

  always @(negedge i_CLK) begin
    if (bus.wren_a || bus.wren_b)
      wr_q.push_back('{cyc, bus.address_a, bus.data_a, bus.address_b, bus.data_b,
                       bus.wren_a, bus.wren_b});
    if (o_done) done_q.push_back(cyc);
    if (bus.rden_a || bus.rden_b) rden_seen = 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc %0d", cyc);
    $fatal(1);
  end

  function automatic logic [7:0] ref_word(input logic [7:0] w, input bit c);
    int         im;
    logic [3:0] lo;
    lo = w[3:0];
    im = int'(lo);
    if (im > 7) im = im - 16;
    if (c) begin
      im = -im;
      if (im > 7) im = 7;
    end
    return {w[7:4], 4'(im)};
  endfunction

  // mode: 0 continuous, 1 three-cycle gap before word 2, 2 random gaps,
  // 3 i_start pulse with i_conj flipped while in FILL_B. exp_len 0 skips timing.
  task automatic do_load(input bit conj, input int mode, input int exp_len, input string tag);
    int start_cyc, idx, budget, wait_n, g;
    bit xfer, poked;
    int acc[2];
    wr_q.delete();
    done_q.delete();
    poked = 0; g = 0; acc[0] = -1; acc[1] = -1;
    i_start = 1'b1;
    i_conj  = conj;
    @(posedge i_CLK); #1;
    start_cyc = cyc;
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start got %b want 1", tag, o_busy);
    end
    idx = 0; budget = 0;
    while (idx < 4 && budget < 200) begin
      bus.in_data = words[idx];
      case (mode)
        1: begin
          if (idx == 1 && g < 3) begin bus.in_valid = 1'b0; g++; end
          else bus.in_valid = 1'b1;
        end
        2: bus.in_valid = ($urandom_range(0, 2) != 0);
        default: bus.in_valid = 1'b1;
      endcase
      if (mode == 3 && idx == 1 && !poked) begin
        i_start = 1'b1; i_conj = ~conj; poked = 1;
      end else begin
        i_start = 1'b0;
      end
      xfer = bus.in_valid && bus.in_ready;
      @(posedge i_CLK); #1;
      if (xfer) begin
        if (idx % 2 == 1) acc[idx/2] = cyc;
        idx++;
      end
      budget++;
    end
    bus.in_valid = 1'b0;
    i_start = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++; $display("FAIL %s word_timeout got %0d words want 4", tag, idx);
    end
    wait_n = 0;
    while (done_q.size() == 0 && wait_n < 20) begin
      @(posedge i_CLK); #1; wait_n++;
    end
    @(posedge i_CLK); #1;
    checks++;
    if (done_q.size() != 1) begin
      errors++; $display("FAIL %s done_count got %0d want 1", tag, done_q.size());
    end
    checks++;
    if (wr_q.size() != 2) begin
      errors++; $display("FAIL %s write_count got %0d want 2", tag, wr_q.size());
    end
    for (int p = 0; p < 2 && p < wr_q.size(); p++) begin
      checks++;
      if (wr_q[p].addr_a !== 4'(2*p) || wr_q[p].addr_b !== 4'(2*p+1)) begin
        errors++; $display("FAIL %s pair%0d_addr got %h/%h want %h/%h", tag, p,
                           wr_q[p].addr_a, wr_q[p].addr_b, 4'(2*p), 4'(2*p+1));
      end
      checks++;
      if (wr_q[p].data_a !== ref_word(words[2*p], conj) ||
          wr_q[p].data_b !== ref_word(words[2*p+1], conj)) begin
        errors++; $display("FAIL %s pair%0d_data got %h/%h want %h/%h", tag, p,
                           wr_q[p].data_a, wr_q[p].data_b,
                           ref_word(words[2*p], conj), ref_word(words[2*p+1], conj));
      end
      checks++;
      if (wr_q[p].we_a !== 1'b1 || wr_q[p].we_b !== 1'b1) begin
        errors++; $display("FAIL %s pair%0d_wren got %b%b want 11", tag, p,
                           wr_q[p].we_a, wr_q[p].we_b);
      end
      checks++;
      if (wr_q[p].cyc != acc[p]) begin
        errors++; $display("FAIL %s pair%0d_write_cycle got %0d want %0d", tag, p,
                           wr_q[p].cyc, acc[p]);
      end
    end
    if (done_q.size() == 1 && wr_q.size() == 2) begin
      checks++;
      if (done_q[0] != wr_q[1].cyc + 1) begin
        errors++; $display("FAIL %s done_latency got %0d want %0d", tag, done_q[0], wr_q[1].cyc + 1);
      end
      if (exp_len > 0) begin
        checks++;
        if (done_q[0] - start_cyc + 1 != exp_len) begin
          errors++; $display("FAIL %s load_length got %0d want %0d", tag,
                             done_q[0] - start_cyc + 1, exp_len);
        end
      end
    end
    checks++;
    if (o_busy !== 1'b0 || rden_seen) begin
      errors++; $display("FAIL %s idle_after got busy %b rden %b want 0 0", tag, o_busy, rden_seen);
    end
  endtask

  task automatic test_reset();
    i_RESET = 1'b0; i_start = 1'b0; i_conj = 1'b0;
    bus.in_data = 8'hA5; bus.in_valid = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, bus.in_ready, bus.wren_a, bus.wren_b, bus.address_a,
         bus.address_b, bus.data_a, bus.data_b} !== '0) begin
      errors++; $display("FAIL reset_outputs got busy %b done %b rdy %b we %b%b a %h/%h d %h/%h want all 0",
                         o_busy, o_done, bus.in_ready, bus.wren_a, bus.wren_b,
                         bus.address_a, bus.address_b, bus.data_a, bus.data_b);
    end
    repeat (2) @(posedge i_CLK);
    #1 i_RESET = 1'b1;
    repeat (4) @(posedge i_CLK);
    #1;
    checks++;
    if (o_busy !== 1'b0 || bus.in_ready !== 1'b0 || wr_q.size() != 0) begin
      errors++; $display("FAIL idle_hold got busy %b rdy %b writes %0d want 0 0 0",
                         o_busy, bus.in_ready, wr_q.size());
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_continuous();
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(1'b0, 0, 7, "continuous");
  endtask

  task automatic test_conjugate();
    words = '{8'h1F, 8'h18, 8'h70, 8'h05};
    do_load(1'b1, 0, 7, "conjugate");
    checks++;
    if (wr_q.size() == 2 && (wr_q[0].data_b !== 8'h17 || wr_q[1].data_b !== 8'h0B)) begin
      errors++; $display("FAIL conj_vectors got %h %h want 17 0b", wr_q[0].data_b, wr_q[1].data_b);
    end
  endtask

  task automatic test_source_gaps();
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(1'b0, 1, 10, "source_gaps");
  endtask

  task automatic test_start_during_fill();
    words = '{8'h1F, 8'h18, 8'h70, 8'h05};
    do_load(1'b1, 3, 7, "start_in_fill_conj");
    words = '{8'h8F, 8'h38, 8'hC8, 8'h21};
    do_load(1'b0, 3, 7, "start_in_fill_plain");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
      do_load(1'($urandom_range(0, 1)), 2, 0, "random");
    end
  endtask

  task automatic test_reset_mid_load();
    words = '{8'h5A, 8'hC3, 8'h7E, 8'h81};
    wr_q.delete(); done_q.delete();
    i_start = 1'b1; i_conj = 1'b0;
    @(posedge i_CLK); #1;
    i_start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = words[0];
    @(posedge i_CLK); #1 bus.in_data = words[1];
    @(posedge i_CLK); #1 bus.in_data = words[2];
    @(posedge i_CLK); #1;
    i_RESET = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, bus.in_ready, bus.wren_a, bus.wren_b, bus.address_a,
         bus.address_b, bus.data_a, bus.data_b} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got busy %b rdy %b a %h/%h d %h/%h want all 0",
                         o_busy, bus.in_ready, bus.address_a, bus.address_b, bus.data_a, bus.data_b);
    end
    repeat (3) @(posedge i_CLK);
    #1 i_RESET = 1'b1;
    repeat (3) @(posedge i_CLK);
    #1;
    checks++;
    if (wr_q.size() != 1 || done_q.size() != 0) begin
      errors++; $display("FAIL reset_abort got writes %0d done %0d want 1 0", wr_q.size(), done_q.size());
    end
    checks++;
    if (wr_q.size() >= 1 && (wr_q[0].data_a !== 8'h5A || wr_q[0].data_b !== 8'hC3)) begin
      errors++; $display("FAIL reset_first_pair got %h/%h want 5a/c3", wr_q[0].data_a, wr_q[0].data_b);
    end
    checks++;
    if (o_busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got busy %b rdy %b want 0 0", o_busy, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
    do_load(1'($urandom_range(0, 1)), 0, 7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_conjugate();
    test_source_gaps();
    test_start_during_fill();
    test_random();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
